// File: rtl/pdua_control_unit.sv
// rtl/pdua_control_unit.sv - PDUA fetch/decode/execute microsequencer
//
// Drives every PDUA datapath control strobe from a Moore FSM.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run               level; start/continue execution from IDLE
//   out_IR            opcode currently held in the IR
//   C, N, P, Z        registered ALU flags (only Z is used, by JZ)
//   wr_rdn            1 = memory write from MDR, 0 = read
//   enaf              update flag register
//   selop, shamt      ALU operation select / shift amount (shift unused)
//   bank_wr_en        write BusC into bank[BusC_addr]
//   BusB_addr         bank read select for ALU operand B
//   BusC_addr         bank write select
//   sclr              synchronous clear of IR/MAR/MDR
//   ir_en, mar_en, mdr_en  register load enables
//   mdr_alu_n         BusC source: 1 = MDR, 0 = ALU
//   halted            high while in HALT
//   illegal_op        pulse in DEC for an undefined opcode
module pdua_control_unit #(
    parameter int ADDR_WIDTH = 3,
    parameter int OP_WIDTH   = 5,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR   = 3'd0,
    parameter logic [ADDR_WIDTH-1:0] DPTR_ADDR = 3'd2,
    parameter logic [ADDR_WIDTH-1:0] A_ADDR    = 3'd3,
    parameter logic [ADDR_WIDTH-1:0] ACC_ADDR  = 3'd7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [OP_WIDTH-1:0]   out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  halted,
    output logic                  illegal_op
);

    localparam logic [OP_WIDTH-1:0] OP_NOP      = 5'b00000;
    localparam logic [OP_WIDTH-1:0] OP_MOV_ACCA = 5'b00001;
    localparam logic [OP_WIDTH-1:0] OP_MOV_AACC = 5'b00010;
    localparam logic [OP_WIDTH-1:0] OP_MOV_DACC = 5'b00011;
    localparam logic [OP_WIDTH-1:0] OP_LOAD     = 5'b00100;
    localparam logic [OP_WIDTH-1:0] OP_STORE    = 5'b00101;
    localparam logic [OP_WIDTH-1:0] OP_ADD      = 5'b00110;
    localparam logic [OP_WIDTH-1:0] OP_INV      = 5'b00111;
    localparam logic [OP_WIDTH-1:0] OP_JMP      = 5'b01000;
    localparam logic [OP_WIDTH-1:0] OP_JZ       = 5'b01001;
    localparam logic [OP_WIDTH-1:0] OP_HALT     = 5'b11111;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_NOT   = 3'b010;
    localparam logic [2:0] ALU_INCB  = 3'b011;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_HALT
    } state_t;

    state_t              state;
    logic [OP_WIDTH-1:0] op;
    logic                op_ok;
    logic                unused_flags;

    assign unused_flags = C ^ N ^ P;

    // Opcodes 00000..01001 plus HALT are defined; everything else decodes as NOP.
    assign op_ok = (out_IR <= OP_JZ) || (out_IR == OP_HALT);

    // Instruction boundary: continue fetching only while run is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= '0;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_CLR;
                S_CLR:  state <= S_F0;
                S_F0:   state <= S_F1;
                S_F1:   state <= S_F2;
                S_F2:   state <= S_DEC;
                S_DEC: begin
                    op <= out_IR;
                    if (out_IR == OP_HALT)
                        state <= S_HALT;
                    else if (!op_ok || out_IR == OP_NOP)
                        state <= run ? S_F0 : S_IDLE;
                    else
                        state <= S_E0;
                end
                S_E0: begin
                    if (op == OP_LOAD || op == OP_STORE)
                        state <= S_E1;
                    else
                        state <= run ? S_F0 : S_IDLE;
                end
                S_E1:   state <= S_E2;
                S_E2:   state <= run ? S_F0 : S_IDLE;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_rdn     = 1'b0;
        enaf       = 1'b0;
        selop      = ALU_PASSB;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        BusB_addr  = '0;
        BusC_addr  = '0;
        sclr       = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_alu_n  = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_CLR: sclr = 1'b1;
            S_F0: begin
                BusB_addr = PC_ADDR;
                mar_en    = 1'b1;
            end
            S_F1: begin
                mdr_en     = 1'b1;
                BusB_addr  = PC_ADDR;
                BusC_addr  = PC_ADDR;
                selop      = ALU_INCB;
                bank_wr_en = 1'b1;
            end
            S_F2:  ir_en = 1'b1;
            S_DEC: illegal_op = !op_ok;
            S_E0: begin
                case (op)
                    OP_MOV_ACCA: begin
                        BusB_addr = A_ADDR; BusC_addr = ACC_ADDR; bank_wr_en = 1'b1;
                    end
                    OP_MOV_AACC: begin
                        BusB_addr = ACC_ADDR; BusC_addr = A_ADDR; bank_wr_en = 1'b1;
                    end
                    OP_MOV_DACC: begin
                        BusB_addr = ACC_ADDR; BusC_addr = DPTR_ADDR; bank_wr_en = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        BusB_addr = DPTR_ADDR; mar_en = 1'b1;
                    end
                    OP_ADD: begin
                        BusB_addr = A_ADDR; BusC_addr = ACC_ADDR; selop = ALU_ADD;
                        bank_wr_en = 1'b1; enaf = 1'b1;
                    end
                    OP_INV: begin
                        BusC_addr = ACC_ADDR; selop = ALU_NOT;
                        bank_wr_en = 1'b1; enaf = 1'b1;
                    end
                    OP_JMP: begin
                        BusB_addr = DPTR_ADDR; BusC_addr = PC_ADDR; bank_wr_en = 1'b1;
                    end
                    OP_JZ: begin
                        // Not-taken branch keeps the PC already incremented in F1.
                        if (Z) begin
                            BusB_addr = DPTR_ADDR; BusC_addr = PC_ADDR; bank_wr_en = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_E1: begin
                mdr_en = 1'b1;
                if (op == OP_STORE) begin
                    BusB_addr = ACC_ADDR;
                    selop     = ALU_PASSB;
                end
            end
            S_E2: begin
                if (op == OP_STORE) begin
                    wr_rdn = 1'b1;
                end else begin
                    mdr_alu_n  = 1'b1;
                    BusC_addr  = ACC_ADDR;
                    bank_wr_en = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
        if (unused_flags && 1'b0) halted = 1'b0;
    end

endmodule
